dac_sweep_test: RTL and testbench

- Stand-alone bring-up block for a 16-bit LVDS-style DAC channel (channel 0).
- After reset it pulses the DAC hardware reset, then writes three configuration words over a 3-wire SPI.
- It then streams a free-running 16-bit ramp on a complementary data bus, with a half-rate data clock (DCI0) and DAC clock (CLK_out).
- Sits directly at chip pins; differential pairs are plain complementary logic (n = ~p), with no vendor primitives.

---
 rtl/dac_sweep_test.sv | 234 +++++++++++++++++++++++
 tb/tb_dac_sweep_test.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dac_sweep_test.sv
// Bring-up sequencer for DAC channel 0: hardware reset pulse, three SPI config
// writes, then a free-running ramp on the complementary data bus with DCI/CLK.
module dac_sweep_test #(
    parameter logic [15:0] SWEEP_STEP = 16'd1,
    parameter int          SPI_DIV    = 4,
    parameter int          RST_CYCLES = 16,
    parameter logic [15:0] CFG_WORD0  = 16'h0000,
    parameter logic [15:0] CFG_WORD1  = 16'h0280,
    parameter logic [15:0] CFG_WORD2  = 16'h0300
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] D0_out_p,
    output logic [15:0] D0_out_n,
    output logic        CLK_out_p,
    output logic        CLK_out_n,
    output logic        DCI0_out_p,
    output logic        DCI0_out_n,
    output logic        csb0,
    output logic        rst0,
    output logic        sdo,
    output logic        sck,
    output logic        rst_led
);

    typedef enum logic [2:0] {
        DAC_RST,
        DAC_WAIT,
        SPI_FRAME,
        SPI_GAP,
        RUN
    } state_t;

    localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
    localparam logic [15:0] DIV_LAST = 16'(SPI_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(2 * SPI_DIV - 1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_div;
    logic [3:0]  r_bit;
    logic [15:0] r_shift;
    logic [1:0]  r_widx;
    logic        r_sck;
    logic        r_sdo;
    logic        r_csb;
    logic        r_rst0;
    logic        r_led;
    logic        r_ph;
    logic        r_clk_n;
    logic        r_dci_p;
    logic        r_dci_n;
    logic [15:0] r_ramp;
    logic [15:0] r_d_n;

    state_t      w_state_next;
    logic [15:0] w_cnt_next;
    logic [15:0] w_div_next;
    logic [3:0]  w_bit_next;
    logic [15:0] w_shift_next;
    logic [1:0]  w_widx_next;
    logic        w_sck_next;
    logic        w_sdo_next;
    logic        w_csb_next;
    logic        w_rst0_next;
    logic        w_led_next;
    logic        w_load;
    logic [1:0]  w_load_idx;
    logic [15:0] w_load_word;
    logic        w_dci_next;
    logic [15:0] w_ramp_next;

    function automatic logic [15:0] cfg_word(input logic [1:0] idx);
        case (idx)
            2'd0:    cfg_word = CFG_WORD0;
            2'd1:    cfg_word = CFG_WORD1;
            default: cfg_word = CFG_WORD2;
        endcase
    endfunction

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_div_next   = r_div;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_widx_next  = r_widx;
        w_sck_next   = r_sck;
        w_sdo_next   = r_sdo;
        w_csb_next   = r_csb;
        w_rst0_next  = r_rst0;
        w_led_next   = r_led;
        w_load       = 1'b0;
        w_load_idx   = 2'd0;
        w_load_word  = 16'h0000;

        case (r_state)
            DAC_RST: begin
                if (r_cnt == RST_LAST) begin
                    w_state_next = DAC_WAIT;
                    w_cnt_next   = 16'd0;
                    w_rst0_next  = 1'b0;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            DAC_WAIT: begin
                if (r_cnt == RST_LAST) begin
                    w_load     = 1'b1;
                    w_load_idx = 2'd0;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            SPI_FRAME: begin
                // Each bit: SPI_DIV cycles sck low, then SPI_DIV cycles high.
                if (r_div == DIV_LAST) begin
                    w_div_next = 16'd0;
                    if (!r_sck) begin
                        w_sck_next = 1'b1;
                    end else if (r_bit == 4'd15) begin
                        w_sck_next   = 1'b0;
                        w_csb_next   = 1'b1;
                        w_sdo_next   = 1'b0;
                        w_state_next = SPI_GAP;
                        w_cnt_next   = 16'd0;
                    end else begin
                        w_sck_next   = 1'b0;
                        w_bit_next   = r_bit + 4'd1;
                        w_sdo_next   = r_shift[15];
                        w_shift_next = {r_shift[14:0], 1'b0};
                    end
                end else begin
                    w_div_next = r_div + 16'd1;
                end
            end
            SPI_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_next = 16'd0;
                    if (r_widx == 2'd2) begin
                        w_state_next = RUN;
                        w_led_next   = 1'b0;
                    end else begin
                        w_load     = 1'b1;
                        w_load_idx = r_widx + 2'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            RUN: begin
            end
            default: begin
                w_state_next = DAC_RST;
            end
        endcase

        // Frame start: MSB is presented in the very first cycle with csb0 low.
        if (w_load) begin
            w_load_word  = cfg_word(w_load_idx);
            w_state_next = SPI_FRAME;
            w_cnt_next   = 16'd0;
            w_widx_next  = w_load_idx;
            w_div_next   = 16'd0;
            w_bit_next   = 4'd0;
            w_sck_next   = 1'b0;
            w_csb_next   = 1'b0;
            w_sdo_next   = w_load_word[15];
            w_shift_next = {w_load_word[14:0], 1'b0};
        end
    end

    // DCI follows the phase bit once RUN is reached; the ramp advances as ph falls.
    always_comb begin
        w_dci_next  = (w_state_next == RUN) ? ~r_ph : 1'b0;
        w_ramp_next = r_ramp;
        if (r_state == RUN && r_ph) begin
            w_ramp_next = r_ramp + SWEEP_STEP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= DAC_RST;
            r_cnt   <= 16'd0;
            r_div   <= 16'd0;
            r_bit   <= 4'd0;
            r_shift <= 16'd0;
            r_widx  <= 2'd0;
            r_sck   <= 1'b0;
            r_sdo   <= 1'b0;
            r_csb   <= 1'b1;
            r_rst0  <= 1'b1;
            r_led   <= 1'b1;
            r_ph    <= 1'b0;
            r_clk_n <= 1'b1;
            r_dci_p <= 1'b0;
            r_dci_n <= 1'b1;
            r_ramp  <= 16'd0;
            r_d_n   <= 16'hFFFF;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_div   <= w_div_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_widx  <= w_widx_next;
            r_sck   <= w_sck_next;
            r_sdo   <= w_sdo_next;
            r_csb   <= w_csb_next;
            r_rst0  <= w_rst0_next;
            r_led   <= w_led_next;
            r_ph    <= ~r_ph;
            r_clk_n <= r_ph;
            r_dci_p <= w_dci_next;
            r_dci_n <= ~w_dci_next;
            r_ramp  <= w_ramp_next;
            r_d_n   <= ~w_ramp_next;
        end
    end

    assign D0_out_p   = r_ramp;
    assign D0_out_n   = r_d_n;
    assign CLK_out_p  = r_ph;
    assign CLK_out_n  = r_clk_n;
    assign DCI0_out_p = r_dci_p;
    assign DCI0_out_n = r_dci_n;
    assign csb0       = r_csb;
    assign rst0       = r_rst0;
    assign sdo        = r_sdo;
    assign sck        = r_sck;
    assign rst_led    = r_led;

endmodule

// File: tb/tb_dac_sweep_test.sv
// Bench for dac_sweep_test: timeline model indexed by cycles since reset release,
// checked every cycle on two instances (step 1 and step 0x4000) under random resets.
module tb_dac_sweep_test;

    localparam int RSTC = 16;
    localparam int DIV  = 4;
    localparam int F0   = 2 * RSTC;
    localparam int FLEN = 32 * DIV;
    localparam int GAP  = 2 * DIV;
    localparam int RUNT = F0 + 3 * (FLEN + GAP);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] a_dp, a_dn, b_dp, b_dn;
    logic a_cp, a_cn, a_ip, a_in, a_csb, a_rst0, a_sdo, a_sck, a_led;
    logic b_cp, b_cn, b_ip, b_in, b_csb, b_rst0, b_sdo, b_sck, b_led;

    dac_sweep_test #(.SWEEP_STEP(16'd1)) u_a (
        .clk(clk), .reset(reset),
        .D0_out_p(a_dp), .D0_out_n(a_dn), .CLK_out_p(a_cp), .CLK_out_n(a_cn),
        .DCI0_out_p(a_ip), .DCI0_out_n(a_in), .csb0(a_csb), .rst0(a_rst0),
        .sdo(a_sdo), .sck(a_sck), .rst_led(a_led)
    );

    dac_sweep_test #(.SWEEP_STEP(16'h4000)) u_b (
        .clk(clk), .reset(reset),
        .D0_out_p(b_dp), .D0_out_n(b_dn), .CLK_out_p(b_cp), .CLK_out_n(b_cn),
        .DCI0_out_p(b_ip), .DCI0_out_n(b_in), .csb0(b_csb), .rst0(b_rst0),
        .sdo(b_sdo), .sck(b_sck), .rst_led(b_led)
    );

    int t = 0;
    int total = 0;
    int bad = 0;
    logic [15:0] cfg [3] = '{16'h0000, 16'h0280, 16'h0300};

    always @(posedge clk) begin
        if (reset) t = 0;
        else       t = t + 1;
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s t=%0d got=%h want=%h", nm, t, act, expv);
        end
    endtask

    // Expected pins tt cycles after reset release (tt=0 gives the reset values).
    task automatic check_dut(input string tg, input int tt, input logic [15:0] step,
                             input logic [15:0] dp, input logic [15:0] dn,
                             input logic cp, input logic cn, input logic ip, input logic dcin,
                             input logic csb, input logic r0, input logic sd,
                             input logic sc, input logic led);
        logic e_csb, e_sck, e_sdo, e_dci;
        logic [15:0] e_d, w;
        logic [31:0] prod;
        int k;
        e_csb = 1'b1; e_sck = 1'b0; e_sdo = 1'b0; e_dci = 1'b0; e_d = 16'h0;
        for (int f = 0; f < 3; f++) begin
            int tf;
            tf = F0 + f * (FLEN + GAP);
            if (tt >= tf && tt < tf + FLEN) begin
                k = tt - tf;
                w = cfg[f];
                e_csb = 1'b0;
                e_sck = ((k / DIV) % 2) == 1;
                e_sdo = w[15 - k / (2 * DIV)];
            end
        end
        if (tt >= RUNT) begin
            e_dci = (tt % 2) == 1;
            prod  = 32'(step) * 32'((tt - RUNT) / 2);
            e_d   = prod[15:0];
        end
        chk({tg, "_rst0"}, 16'(r0), 16'(tt < RSTC));
        chk({tg, "_csb0"}, 16'(csb), 16'(e_csb));
        chk({tg, "_sck"}, 16'(sc), 16'(e_sck));
        chk({tg, "_sdo"}, 16'(sd), 16'(e_sdo));
        chk({tg, "_led"}, 16'(led), 16'(tt < RUNT));
        chk({tg, "_clkp"}, 16'(cp), 16'((tt % 2) == 1));
        chk({tg, "_clkn"}, 16'(cn), 16'((tt % 2) == 0));
        chk({tg, "_dcip"}, 16'(ip), 16'(e_dci));
        chk({tg, "_dcin"}, 16'(dcin), 16'(!e_dci));
        chk({tg, "_dp"}, dp, e_d);
        chk({tg, "_dn"}, dn, ~e_d);
    endtask

    // Frame decoder state (sdo sampled on sck rising edges of instance A).
    logic prev_sck = 1'b0;
    logic prev_csb = 1'b1;
    logic [15:0] sh = 16'h0;
    int nb = 0;
    int lowc = 0;
    int fidx = 0;

    always @(negedge clk) begin
        if (reset) begin
            check_dut("a", 0, 16'd1, a_dp, a_dn, a_cp, a_cn, a_ip, a_in, a_csb, a_rst0, a_sdo, a_sck, a_led);
            check_dut("b", 0, 16'h4000, b_dp, b_dn, b_cp, b_cn, b_ip, b_in, b_csb, b_rst0, b_sdo, b_sck, b_led);
            prev_sck = 1'b0; prev_csb = 1'b1; nb = 0; lowc = 0; fidx = 0; sh = 16'h0;
        end else begin
            check_dut("a", t, 16'd1, a_dp, a_dn, a_cp, a_cn, a_ip, a_in, a_csb, a_rst0, a_sdo, a_sck, a_led);
            check_dut("b", t, 16'h4000, b_dp, b_dn, b_cp, b_cn, b_ip, b_in, b_csb, b_rst0, b_sdo, b_sck, b_led);
            if (t == 15)  chk("pin_rst0_hi", 16'(a_rst0), 16'd1);
            if (t == 16)  chk("pin_rst0_lo", 16'(a_rst0), 16'd0);
            if (t == 31)  chk("pin_csb_hi", 16'(a_csb), 16'd1);
            if (t == 32)  chk("pin_csb_fall", 16'(a_csb), 16'd0);
            if (t == 439) chk("pin_led_hi", 16'(a_led), 16'd1);
            if (t == 440) chk("pin_led_lo", 16'(a_led), 16'd0);
            if (t == 444) chk("pin_ramp2", a_dp, 16'h0002);
            if (t == 442) chk("pin_b_4000", b_dp, 16'h4000);
            if (t == 446) chk("pin_b_c000", b_dp, 16'hC000);
            if (t == 448) chk("pin_b_wrap", b_dp, 16'h0000);
            if (!a_csb) lowc++;
            if (a_sck && !prev_sck) begin
                sh = {sh[14:0], a_sdo};
                nb++;
            end
            if (a_csb && !prev_csb) begin
                chk("frame_len", 16'(lowc), 16'd128);
                chk("frame_sck_pulses", 16'(nb), 16'd16);
                case (fidx)
                    0:       chk("frame0", sh, 16'h0000);
                    1:       chk("frame1", sh, 16'h0280);
                    default: chk("frame2", sh, 16'h0300);
                endcase
                $display("frame %0d decoded %h at t=%0d", fidx, sh, t);
                fidx++; nb = 0; lowc = 0;
            end
            prev_sck = a_sck;
            prev_csb = a_csb;
        end
    end

    task automatic wait_t(input int x);
        do begin
            @(posedge clk);
            #1;
        end while (t < x);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    // Outputs must be at reset values right after the asynchronous assertion.
    task automatic chk_async(input string nm);
        chk({nm, "_a_csb"}, 16'(a_csb), 16'd1);
        chk({nm, "_a_sck"}, 16'(a_sck), 16'd0);
        chk({nm, "_a_sdo"}, 16'(a_sdo), 16'd0);
        chk({nm, "_a_rst0"}, 16'(a_rst0), 16'd1);
        chk({nm, "_a_dp"}, a_dp, 16'h0000);
        chk({nm, "_a_dn"}, a_dn, 16'hFFFF);
        chk({nm, "_a_dci"}, 16'(a_ip), 16'd0);
        chk({nm, "_a_led"}, 16'(a_led), 16'd1);
        chk({nm, "_b_dp"}, b_dp, 16'h0000);
        chk({nm, "_b_csb"}, 16'(b_csb), 16'd1);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        release_reset();
        wait_t(RUNT + 160);
        $display("run reached, ramp a=%h b=%h", a_dp, b_dp);

        // Reset in frame 1, bit 7.
        wait_t(F0 + FLEN + GAP + 58);
        #2 reset = 1'b1;
        #1 chk_async("mid_frame");
        repeat (2) @(posedge clk);
        release_reset();

        // Run until ramp reaches 0x1234, then reset during RUN.
        wait_t(RUNT + 2 * 16'h1234);
        chk("ramp_1234", a_dp, 16'h1234);
        #1 reset = 1'b1;
        #1 chk_async("in_run");
        repeat (2) @(posedge clk);
        release_reset();
        wait_t(RUNT + 40);

        for (int i = 0; i < 6; i++) begin
            wait_t(int'($urandom_range(5, 700)));
            #(int'($urandom_range(1, 2)));
            reset = 1'b1;
            #1 chk_async("rand");
            repeat (int'($urandom_range(1, 4))) @(posedge clk);
            release_reset();
            $display("random reset %0d done", i);
        end
        wait_t(RUNT + 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
